// File: rtl/mult_ctrl_pkg.sv
// rtl/mult_ctrl_pkg.sv - shared state type, default widths and negate helper for seq_mult_controller
package mult_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DONE} state_t;

   localparam int DEF_DW   = 8;
   localparam int DEF_DW_2 = 2 * DEF_DW;

   // Wide enough for any operand or product width; callers truncate the return value.
   localparam int NEG_W = 64;

   function automatic logic [NEG_W-1:0] neg2c(input logic [NEG_W-1:0] v);
      return ~v + NEG_W'(1);
   endfunction

endpackage

// File: rtl/tc_magnitude.sv
// rtl/tc_magnitude.sv - two's-complement magnitude and sign split of one operand
// With SIGNED_OPS=0 the value passes through unchanged and sign is 0.
module tc_magnitude
   import mult_ctrl_pkg::*;
#(
   parameter int DW         = DEF_DW,
   parameter bit SIGNED_OPS = 1'b1
) (
   input  logic [DW-1:0] value,
   output logic [DW-1:0] mag,
   output logic          sign
);

   assign sign = SIGNED_OPS ? value[DW-1] : 1'b0;

   // The most negative value negates to itself, which reads correctly as an unsigned 2^(DW-1).
   assign mag = sign ? DW'(neg2c(NEG_W'(value))) : value;

endmodule

// File: rtl/seq_mult_controller.sv
// rtl/seq_mult_controller.sv - sequences the shared sweep adder for one DWxDW multiply per request
// Define SEQ_MULT_CTRL_SIGNED_EN for two's-complement operands; unsigned otherwise.
module seq_mult_controller
   import mult_ctrl_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int DW_2    = 2 * DW,
   parameter int DWlogb2 = $clog2(DW)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            ready,
   input  logic [DW-1:0]   multiplier,
   input  logic [DW-1:0]   multiplicand,
   output logic            add_l_s,
   output logic            add_init,
   output logic            add_permit,
   output logic [DW-1:0]   add_rgstr1,
   output logic [DW_2-1:0] add_rgstr2,
   input  logic            add_done,
   input  logic [DW_2-1:0] add_product,
   output logic [DW_2-1:0] result,
   output logic            result_valid,
   input  logic            result_ready,
   output logic            err
);

`ifdef SEQ_MULT_CTRL_SIGNED_EN
   localparam bit SIGNED_OPS = 1'b1;
`else
   localparam bit SIGNED_OPS = 1'b0;
`endif

   localparam logic [DWlogb2:0] K_LAST = (DWlogb2 + 1)'(DW - 1);

   state_t            state;
   state_t            state_nxt;
   logic [DW-1:0]     mag_a;
   logic [DW-1:0]     mag_b;
   logic              neg;
   logic [DWlogb2:0]  k;
   logic [DW_2-1:0]   base;

   logic [DW-1:0]     in_mag_a;
   logic [DW-1:0]     in_mag_b;
   logic              in_sign_a;
   logic              in_sign_b;
   logic [DW_2-1:0]   diff;
   logic [DW_2-1:0]   diff_neg;

   tc_magnitude #(.DW(DW), .SIGNED_OPS(SIGNED_OPS)) u_mag_a (
      .value (multiplier),
      .mag   (in_mag_a),
      .sign  (in_sign_a)
   );

   tc_magnitude #(.DW(DW), .SIGNED_OPS(SIGNED_OPS)) u_mag_b (
      .value (multiplicand),
      .mag   (in_mag_b),
      .sign  (in_sign_b)
   );

   // The adder accumulator is never cleared, so the product is taken relative to the LOAD snapshot.
   assign diff     = add_product - base;
   assign diff_neg = DW_2'(neg2c(NEG_W'(diff)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         mag_a  <= '0;
         mag_b  <= '0;
         neg    <= 1'b0;
         k      <= '0;
         base   <= '0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  mag_a <= in_mag_a;
                  mag_b <= in_mag_b;
                  neg   <= in_sign_a ^ in_sign_b;
               end
            end
            LOAD: begin
               base <= add_product;
               k    <= '0;
            end
            RUN: begin
               k <= k + 1'b1;
            end
            CAPTURE: begin
               result <= neg ? diff_neg : diff;
               if (!add_done) begin
                  err <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_nxt    = state;
      ready        = 1'b0;
      result_valid = 1'b0;
      add_l_s      = 1'b0;
      add_init     = 1'b0;
      add_permit   = 1'b1;
      add_rgstr1   = '0;
      add_rgstr2   = '0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            add_init  = 1'b1;
            add_l_s   = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            add_init   = 1'b1;
            add_permit = 1'b0;
            add_rgstr1 = mag_a;
            add_rgstr2 = DW_2'(mag_b) << k;
            if (k == K_LAST) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            add_init  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: doc/seq_mult_controller.md
# seq_mult_controller

Control unit that sequences the shared sweep adder datapath to perform one DW×DW multiplication per request. It registers the operands, converts signed operands to magnitudes, and drives the adder's l_s/init_FSM/permit controls and its rgstr1/rgstr2 operands for DW cycles. It then takes the adder product, removes the accumulator baseline, applies the sign, and returns the result over a valid/ready handshake. It sits between the request interface and the adder.

## Interface
- DW, 8, operand width
- DW_2, 2*DW, product width
- DWlogb2, $clog2(DW), iteration counter width minus one
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request valid
- ready  out  1  high in IDLE; request accepted on start&&ready
- multiplier  in  DW  operand A
- multiplicand  in  DW  operand B
- add_l_s  out  1  to adder l_s
- add_init  out  1  to adder init_FSM
- add_permit  out  1  to adder permit
- add_rgstr1  out  DW  to adder rgstr1 (|A|)
- add_rgstr2  out  DW_2  to adder rgstr2 (|B| shifted)
- add_done  in  1  from adder done
- add_product  in  DW_2  from adder product
- result  out  DW_2  final product
- result_valid  out  1  result held valid
- result_ready  in  1  consumer accepts result
- err  out  1  sticky: add_done low at CAPTURE

## Operation
- Adder behaviour the controller relies on:
  - In each cycle with init=1, l_s=0, permit=0, the adder adds rgstr2 when rgstr1[count]=1, then increments count.
  - done is registered high the cycle after count==DW-1.
  - l_s=1 zeroes count. permit=1 freezes the adder.
  - The accumulator is never cleared except by reset.
- States: IDLE, LOAD, RUN, CAPTURE, DONE.
- IDLE: ready=1. On start, register magA=|A|, magB=|B|, neg=A[DW-1]^B[DW-1], then go to LOAD.
- LOAD: add_init=1, add_l_s=1. Snapshot base<=add_product. k<=0. Go to RUN.
- RUN: add_init=1, add_l_s=0, add_permit=0, add_rgstr1=magA, add_rgstr2=zero-extended magB<<k. k increments each cycle. After k==DW-1, go to CAPTURE.
- CAPTURE: add_init=1, add_permit=1. diff=add_product-base, modulo 2^DW_2. result<=neg ? -diff : diff. If add_done==0, set err. Go to DONE.
- DONE: result_valid=1. On result_ready, go to IDLE.
- Outside RUN: add_permit=1 and add_rgstr2=0.
- Magnitude of the most negative value (e.g. -128) is 2^(DW-1), which is representable unsigned in DW bits.
- start outside IDLE is ignored and not queued.
- result and result_valid are held stable until accepted.

## Timing
- Reset values:
  - State = IDLE, ready=1.
  - add_l_s=0, add_init=0, add_permit=1.
  - add_rgstr1=0, add_rgstr2=0.
  - result=0, result_valid=0, err=0.
  - Internal registers = 0.
- Handshake at cycle T: LOAD at T+1, RUN at T+2..T+DW+1, CAPTURE at T+DW+2, result_valid from T+DW+3. Latency is DW+3.
- Same-cycle result_valid&&result_ready leaves ready high in the next cycle. Minimum issue interval is DW+4.
- Reset mid-operation: immediate return to reset values. The adder shares rst, so its baseline is also cleared.
- err clears only on reset.

## Configuration
- SEQ_MULT_CTRL_SIGNED_EN defined: operands are two's complement; magnitudes and sign correction are applied as above.
- Not defined: operands are unsigned; magA=A, magB=B, neg=0, result=diff.

## Structure
- Package mult_ctrl_pkg:
  - State enum: IDLE, LOAD, RUN, CAPTURE, DONE.
  - Default DW/DW_2 localparams.
  - Function for the two's-complement negate used by both magnitude and sign correction.
- One sub-module, tc_magnitude (DW in → DW magnitude + sign out), instantiated twice. Bypassed when SEQ_MULT_CTRL_SIGNED_EN is undefined.
- All else in one always_ff and one always_comb FSM.

## Test plan
- Basic unsigned product: 3×5, DW=8, with the adder model instantiated → result=15, result_valid exactly 11 cycles after the accept edge.
- Signed, one negative (SIGNED_EN): -3×5 → result=16'hFFF1.
- Signed, most negative: -128×-128 → 16384, err=0.
- Back-to-back, accumulator not cleared: 7×9 then 2×3, without reset → results 63 then 6, baseline removed.
- Output backpressure and busy: result_ready low for 20 cycles → result held stable; start pulsed during RUN and DONE → ignored, ready=0 throughout.
- Reset mid-RUN: assert rst at RUN k=4 → all outputs at reset values; a new 6×7 request afterwards → 42.
